digit_template_scorer: RTL
==========================

// Module: digit_template_scorer
// PURPOSE
// - Read-side master for the 4096x1 digit-template pROMs (bypass read, 1-cycle latency, 0 = ink, 1 = background).
// - On start, scans one template ROM and the captured binarized 64x64 sample bitmap in lockstep.
// - Counts mismatching pixels (Hamming distance) and reports the count for the recognition arbiter.
// - Instantiated once per template digit; the lowest score wins.
// PARAMETERS
// - ADDR_W  12    ROM/sample address width
// - DEPTH   4096  pixels scanned, addresses 0..DEPTH-1, DEPTH <= 2**ADDR_W
// - CNT_W   13    score width, must hold DEPTH
// PORTS
// - clk       in   1       system clock, all logic on rising edge
// - reset     in   1       synchronous, active-high reset
// - start     in   1       begin scan; sampled only in IDLE
// - busy      out  1       high while a scan is in progress
// - done      out  1       one-cycle pulse when score is updated
// - score     out  CNT_W   mismatch count of last completed scan; held until next done
// - rom_ad    out  ADDR_W  template ROM address
// - rom_ce    out  1       ROM clock enable
// - rom_oce   out  1       ROM output clock enable, equals rom_ce
// - rom_dout  in   1       ROM data, valid the cycle after rom_ad/rom_ce
// - smp_ad    out  ADDR_W  sample-bitmap RAM read address, always equals rom_ad
// - smp_dout  in   1       sample data, same 1-cycle latency as rom_dout
// BEHAVIOUR
// - Reset (sync, active-high): state IDLE; busy=0, done=0, score=0, rom_ad=smp_ad=0, rom_ce=rom_oce=0; accumulator cleared.
// - FSM IDLE -> SCAN on start=1. SCAN -> DRAIN after address DEPTH-1 is issued. DRAIN -> DONE. DONE -> IDLE.
// - Edge E0 samples start. Address k (0..DEPTH-1) is driven during cycle k after E0, with rom_ce=1.
// - Data for address k is present during cycle k+1 and is accumulated at the end of that cycle.
// - Compare: mismatch = rom_dout ^ smp_dout. Accumulator is CNT_W bits; it cannot overflow (max DEPTH).
// - A valid-bit pipeline, delayed one cycle from address issue, gates accumulation. No accumulation in IDLE or DONE.
// - rom_ce=0 and rom_ad is held at its last value outside SCAN. The DRAIN cycle only captures the final data beat.
// - busy=1 in cycles 0..DEPTH after E0.
// - At edge E(DEPTH+1): score <= final accumulator and done=1 for exactly that cycle; the accumulator is then cleared.
// - Next start is accepted no earlier than the cycle after done.
// - start while busy or done: ignored, with no effect on the scan in progress. start held high continuously: rescans back-to-back.
// - Reset mid-scan: abort immediately. All outputs return to reset values, including score=0. No done pulse.
// - rom_dout/smp_dout are don't-care when no read is pending.
// TESTING
// - ROM all 1, sample all 1, pulse start -> done 4097 edges after the start edge, score=0; busy high for 4097 cycles.
// - ROM all 1, sample all 0 -> score=4096 (13'h1000), no wrap.
// - Sample equals ROM except pixel 4095 inverted -> score=1, proving the last beat is counted in DRAIN. Repeat with pixel 0 inverted -> score=1.
// - Load the digit-5 template, sample it against itself and against a digit-1 bitmap -> 0 and the precomputed XOR popcount respectively.
// - Pulse start again at scan address 100 -> ignored, single done, correct score. Assert reset at address 2000 -> busy=0, score=0, no done, rom_ce=0 next cycle.
// - Check address sequencing: rom_ad==smp_ad every cycle, increments by 1 from 0 to 4095 with no gaps or repeats, rom_oce==rom_ce.

Source files
------------

// File: rtl/digit_template_scorer.sv
// digit_template_scorer
// Read-side master for one 4096x1 digit-template pROM. On start it reads the
// template ROM and the captured binarized sample bitmap in lockstep, counts the
// pixels where they disagree (Hamming distance) and reports that count as the
// score for the recognition arbiter (lowest score wins).
//
// Ports
//   clk         in   1       system clock, rising edge
//   reset       in   1       synchronous, active-high
//   start       in   1       begin a scan; only looked at in IDLE
//   busy        out  1       high while a scan is in progress
//   done        out  1       one-cycle pulse when score is updated
//   score       out  CNT_W   mismatch count of last completed scan
//   rom_ad      out  ADDR_W  template ROM address
//   rom_ce      out  1       ROM clock enable
//   rom_oce     out  1       ROM output clock enable (same as rom_ce)
//   rom_dout    in   1       ROM data, valid one cycle after the address
//   smp_ad      out  ADDR_W  sample bitmap address (same as rom_ad)
//   smp_dout    in   1       sample data, same one-cycle latency
//   o_dbg_state out  2       FSM state: 0 IDLE, 1 SCAN, 2 DRAIN, 3 DONE
//
// Handshake: start is a level that is consumed only in IDLE; a scan then runs to
// completion (or until reset) and signals its result with a single done pulse,
// during which score already holds the new value. There is no back-pressure.
module digit_template_scorer #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096,
  parameter int CNT_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  score,
  output logic [ADDR_W-1:0] rom_ad,
  output logic              rom_ce,
  output logic              rom_oce,
  input  logic              rom_dout,
  output logic [ADDR_W-1:0] smp_ad,
  input  logic              smp_dout,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_AD = ADDR_W'(DEPTH - 1);

  state_t             r_state;
  state_t             w_next;
  logic [ADDR_W-1:0]  r_ad;
  logic               r_vld;    // a read was issued last cycle, data is on the bus now
  logic [CNT_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_score;
  logic               w_mis;
  logic [CNT_W-1:0]   w_mis_ext;

  assign w_mis     = rom_dout ^ smp_dout;
  assign w_mis_ext = {{(CNT_W-1){1'b0}}, w_mis};

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SCAN;
      S_SCAN:  if (r_ad == LAST_AD) w_next = S_DRAIN;
      S_DRAIN: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ad    <= '0;
      r_vld   <= 1'b0;
      r_acc   <= '0;
      r_score <= '0;
    end else begin
      r_state <= w_next;
      r_vld   <= (r_state == S_SCAN);

      // Address restarts at 0 on start, walks up during SCAN and is held at
      // its last value everywhere else.
      if (r_state == S_IDLE && start) begin
        r_ad <= '0;
      end else if (r_state == S_SCAN && r_ad != LAST_AD) begin
        r_ad <= r_ad + ADDR_W'(1);
      end

      // DRAIN carries the data beat of the last address: fold it straight
      // into the published score and clear the accumulator for the next scan.
      if (r_state == S_DRAIN) begin
        r_score <= r_vld ? (r_acc + w_mis_ext) : r_acc;
        r_acc   <= '0;
      end else if (r_state == S_SCAN && r_vld) begin
        r_acc <= r_acc + w_mis_ext;
      end
    end
  end

  assign busy        = (r_state == S_SCAN) || (r_state == S_DRAIN);
  assign done        = (r_state == S_DONE);
  assign score       = r_score;
  assign rom_ad      = r_ad;
  assign smp_ad      = r_ad;
  assign rom_ce      = (r_state == S_SCAN);
  assign rom_oce     = rom_ce;
  assign o_dbg_state = r_state;

endmodule
